// File: rtl/parking_pkg.sv
// parking_pkg
// Shared types and constants for the parking gate manager:
//   - entry_state_t   : entry barrier FSM states (IDLE, OPEN)
//   - DEF_*           : default capacity, quota schedule and gate timeout
//   - calc_gen_quota  : hour-dependent general quota
package parking_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OPEN = 1'b1
   } entry_state_t;

   localparam int DEF_TOTAL_SPOTS  = 700;
   localparam int DEF_UNI_SPOTS    = 500;
   localparam int DEF_CNT_W        = 10;
   localparam int DEF_HOUR_W       = 5;
   localparam int DEF_GEN_BASE     = 200;
   localparam int DEF_GEN_STEP     = 50;
   localparam int DEF_RAMP_START   = 13;
   localparam int DEF_RAMP_END     = 16;
   localparam int DEF_GATE_TIMEOUT = 16;

   // First hour of the restricted daytime quota.
   localparam int QUOTA_DAY_START  = 8;

   // General quota for a given hour. Outside the daytime window every spot
   // not held by a university car is open to general cars.
   function automatic int calc_gen_quota(input int hour, uni_parked, total_spots,
                                         gen_base, gen_step, ramp_start, ramp_end);
      int quota;
      if (hour >= QUOTA_DAY_START && hour < ramp_start)
         quota = gen_base;
      else if (hour >= ramp_start && hour < ramp_end)
         quota = gen_base + gen_step * (hour - ramp_start + 1);
      else
         quota = total_spots - uni_parked;
      return quota;
   endfunction

endpackage

// File: rtl/parking_entry_gate.sv
// parking_entry_gate
// Entry barrier FSM with gate timeout and latched car class.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req, is_uni    : entry request and class of the requesting car
//   admit          : admission decision from the counters (combinational)
//   pass           : pass-sensor pulse, only meaningful while OPEN
//   ready          : high in IDLE; a request is taken when req && ready
//   grant_now      : combinational strobe, request admitted this cycle
//   rollback       : combinational strobe, last open cycle expired without pass
//   grant, deny, timeout : registered one-cycle result pulses
//   gate_open      : barrier command, high while OPEN
//   latched_uni    : class of the car holding the pending reservation
//   state          : current FSM state (debug / pending indicator)
//
// Handshake: a request transfers on a rising edge where req && ready; the
// result (grant or deny) is a registered pulse in the following cycle. ready
// stays low for the whole OPEN period, so requests then are simply not taken.
module parking_entry_gate
   import parking_pkg::*;
#(
   parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   input  logic         is_uni,
   input  logic         admit,
   input  logic         pass,
   output logic         ready,
   output logic         grant_now,
   output logic         rollback,
   output logic         grant,
   output logic         deny,
   output logic         timeout,
   output logic         gate_open,
   output logic         latched_uni,
   output entry_state_t state
);

   localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

   entry_state_t     state_next;
   logic [TMR_W-1:0] timer, timer_next;
   logic             latched_uni_next;
   logic             deny_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         latched_uni <= 1'b0;
         grant       <= 1'b0;
         deny        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_next;
         timer       <= timer_next;
         latched_uni <= latched_uni_next;
         grant       <= grant_now;
         deny        <= deny_now;
         timeout     <= rollback;
      end
   end

   always_comb begin
      state_next       = state;
      timer_next       = timer;
      latched_uni_next = latched_uni;
      grant_now        = 1'b0;
      deny_now         = 1'b0;
      rollback         = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (admit) begin
                  grant_now        = 1'b1;
                  latched_uni_next = is_uni;
                  timer_next       = '0;
                  state_next       = OPEN;
               end else begin
                  deny_now = 1'b1;
               end
            end
         end
         OPEN: begin
            // timer counts completed open cycles; a pass on the final open
            // cycle still wins over the timeout.
            if (pass) begin
               state_next = IDLE;
            end else if (timer == TMR_LAST) begin
               rollback   = 1'b1;
               state_next = IDLE;
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ready     = (state == IDLE);
   assign gate_open = (state == OPEN);

endmodule

// File: rtl/parking_gate_manager.sv
// parking_gate_manager
// Lot occupancy controller with gated entry, reservation timeout and an
// hour-dependent general quota.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   current_hour            : hour of day (0..23)
//   ent_req, ent_is_uni     : entry request and car class
//   ent_ready               : entry can accept a request (IDLE)
//   ent_pass                : pass-sensor pulse from the gate
//   ent_grant/deny/timeout  : one-cycle result pulses
//   gate_open               : entry barrier command
//   ex_req, ex_is_uni       : exit event and car class
//   ex_err                  : one-cycle pulse, exit refused (would underflow)
//   parked_car, uni_parked_car : registered occupancy incl. pending reservation
//   gen_quota, gen_vacant, uni_vacant : combinational status
//   gen_full, uni_full      : vacancy reached zero
module parking_gate_manager
   import parking_pkg::*;
#(
   parameter int TOTAL_SPOTS  = DEF_TOTAL_SPOTS,
   parameter int UNI_SPOTS    = DEF_UNI_SPOTS,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int HOUR_W       = DEF_HOUR_W,
   parameter int GEN_BASE     = DEF_GEN_BASE,
   parameter int GEN_STEP     = DEF_GEN_STEP,
   parameter int RAMP_START   = DEF_RAMP_START,
   parameter int RAMP_END     = DEF_RAMP_END,
   parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HOUR_W-1:0] current_hour,
   input  logic              ent_req,
   input  logic              ent_is_uni,
   output logic              ent_ready,
   input  logic              ent_pass,
   output logic              ent_grant,
   output logic              ent_deny,
   output logic              ent_timeout,
   output logic              gate_open,
   input  logic              ex_req,
   input  logic              ex_is_uni,
   output logic              ex_err,
   output logic [CNT_W-1:0]  parked_car,
   output logic [CNT_W-1:0]  uni_parked_car,
   output logic [CNT_W-1:0]  gen_quota,
   output logic [CNT_W-1:0]  gen_vacant,
   output logic [CNT_W-1:0]  uni_vacant,
   output logic              gen_full,
   output logic              uni_full
);

   entry_state_t     entry_state;
   logic             latched_uni;
   logic             grant_now, rollback;
   logic             admit, has_room;
   logic             pend_uni, pend_gen;
   logic             ex_ok, ex_block;
   logic [CNT_W-1:0] gen_parked, settled_uni, settled_gen;
   logic [CNT_W-1:0] parked_next, uni_next;
   int               quota_int;

   parking_entry_gate #(
      .GATE_TIMEOUT (GATE_TIMEOUT)
   ) u_entry (
      .clk         (clk),
      .reset       (reset),
      .req         (ent_req),
      .is_uni      (ent_is_uni),
      .admit       (admit),
      .pass        (ent_pass),
      .ready       (ent_ready),
      .grant_now   (grant_now),
      .rollback    (rollback),
      .grant       (ent_grant),
      .deny        (ent_deny),
      .timeout     (ent_timeout),
      .gate_open   (gate_open),
      .latched_uni (latched_uni),
      .state       (entry_state)
   );

   // Status: all derived from registered counts plus the live hour.
   always_comb begin
      gen_parked = parked_car - uni_parked_car;
      quota_int  = calc_gen_quota(int'(current_hour), int'(uni_parked_car), TOTAL_SPOTS,
                                  GEN_BASE, GEN_STEP, RAMP_START, RAMP_END);
      gen_quota  = CNT_W'(quota_int);
      // Quota can fall below occupancy when the hour changes; clamp at zero.
      gen_vacant = (gen_quota > gen_parked) ? (gen_quota - gen_parked) : '0;
      uni_vacant = CNT_W'(UNI_SPOTS) - uni_parked_car;
      gen_full   = (gen_vacant == '0);
      uni_full   = (uni_vacant == '0);
   end

   // Admission: a uni car only ever takes a uni spot.
   always_comb begin
      has_room = (parked_car < CNT_W'(TOTAL_SPOTS));
      if (ent_is_uni)
         admit = has_room && (uni_parked_car < CNT_W'(UNI_SPOTS));
      else
         admit = has_room && (gen_parked < gen_quota);
   end

   // Exits may only release settled cars, never the car still at the gate.
   always_comb begin
      pend_uni    = (entry_state == OPEN) && latched_uni;
      pend_gen    = (entry_state == OPEN) && !latched_uni;
      settled_uni = uni_parked_car - CNT_W'(pend_uni);
      settled_gen = gen_parked - CNT_W'(pend_gen);
      if (ex_is_uni)
         ex_ok = ex_req && (settled_uni != '0);
      else
         ex_ok = ex_req && (settled_gen != '0);
      ex_block = ex_req && !ex_ok;
   end

   // Grant, rollback and exit can coincide; each contributes its own delta.
   always_comb begin
      parked_next = parked_car
                  + CNT_W'(grant_now)
                  - CNT_W'(rollback)
                  - CNT_W'(ex_ok);
      uni_next    = uni_parked_car
                  + CNT_W'(grant_now && ent_is_uni)
                  - CNT_W'(rollback && latched_uni)
                  - CNT_W'(ex_ok && ex_is_uni);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         parked_car     <= '0;
         uni_parked_car <= '0;
         ex_err         <= 1'b0;
      end else begin
         parked_car     <= parked_next;
         uni_parked_car <= uni_next;
         ex_err         <= ex_block;
      end
   end

endmodule

// File: tb/tb_parking_gate_manager.sv
// tb_parking_gate_manager
// Directed bench for parking_gate_manager: a per-cycle occupancy model
// (settled counts per class plus one pending reservation) predicts every
// output; hand-computed literals pin key points of the scenario.
module tb_parking_gate_manager;

   localparam int CNT_W  = 10;
   localparam int HOUR_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [HOUR_W-1:0] current_hour;
   logic              ent_req, ent_is_uni, ent_pass;
   logic              ex_req, ex_is_uni;
   logic              ent_ready, ent_grant, ent_deny, ent_timeout, gate_open, ex_err;
   logic [CNT_W-1:0]  parked_car, uni_parked_car, gen_quota, gen_vacant, uni_vacant;
   logic              gen_full, uni_full;

   always #5 clk = ~clk;

   parking_gate_manager dut (
      .clk            (clk),
      .reset          (reset),
      .current_hour   (current_hour),
      .ent_req        (ent_req),
      .ent_is_uni     (ent_is_uni),
      .ent_ready      (ent_ready),
      .ent_pass       (ent_pass),
      .ent_grant      (ent_grant),
      .ent_deny       (ent_deny),
      .ent_timeout    (ent_timeout),
      .gate_open      (gate_open),
      .ex_req         (ex_req),
      .ex_is_uni      (ex_is_uni),
      .ex_err         (ex_err),
      .parked_car     (parked_car),
      .uni_parked_car (uni_parked_car),
      .gen_quota      (gen_quota),
      .gen_vacant     (gen_vacant),
      .uni_vacant     (uni_vacant),
      .gen_full       (gen_full),
      .uni_full       (uni_full)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit model_valid = 1'b0;
   int m_uni, m_gen;         // settled cars per class
   bit m_pend, m_pend_uni;   // car granted but not yet through the gate
   int m_age;                // open cycles spent by the pending car
   bit e_grant, e_deny, e_timeout, e_err;

   function automatic int model_quota(input int hour, input int uni_total);
      if (hour >= 8 && hour <= 12) return 200;
      if (hour == 13) return 250;
      if (hour == 14) return 300;
      if (hour == 15) return 350;
      return 700 - uni_total;
   endfunction

   task automatic model_step();
      int tu, tp, tg, q;
      bit ok;
      if (reset) begin
         m_uni = 0; m_gen = 0; m_pend = 0; m_pend_uni = 0; m_age = 0;
         e_grant = 0; e_deny = 0; e_timeout = 0; e_err = 0;
         model_valid = 1'b1;
         return;
      end
      if (!model_valid) return;
      tu = m_uni + ((m_pend && m_pend_uni) ? 1 : 0);
      tp = m_uni + m_gen + (m_pend ? 1 : 0);
      tg = tp - tu;
      q  = model_quota(int'(current_hour), tu);
      e_grant = 0; e_deny = 0; e_timeout = 0; e_err = 0;
      if (ex_req) begin
         if (ex_is_uni) begin
            if (m_uni > 0) m_uni--; else e_err = 1;
         end else begin
            if (m_gen > 0) m_gen--; else e_err = 1;
         end
      end
      if (!m_pend) begin
         if (ent_req) begin
            ok = (tp < 700) && (ent_is_uni ? (tu < 500) : (tg < q));
            if (ok) begin
               m_pend = 1; m_pend_uni = ent_is_uni; m_age = 0; e_grant = 1;
            end else begin
               e_deny = 1;
            end
         end
      end else begin
         m_age++;
         if (ent_pass) begin
            m_pend = 0;
            if (m_pend_uni) m_uni++; else m_gen++;
         end else if (m_age == 16) begin
            m_pend = 0;
            e_timeout = 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- compare process ----------------
   task automatic compare_all();
      int tu, tp, tg, q, gv;
      tu = m_uni + ((m_pend && m_pend_uni) ? 1 : 0);
      tp = m_uni + m_gen + (m_pend ? 1 : 0);
      tg = tp - tu;
      q  = model_quota(int'(current_hour), tu);
      gv = (q > tg) ? q - tg : 0;
      check("cmp_parked",      32'(parked_car),     32'(tp));
      check("cmp_uni_parked",  32'(uni_parked_car), 32'(tu));
      check("cmp_gen_quota",   32'(gen_quota),      32'(q));
      check("cmp_gen_vacant",  32'(gen_vacant),     32'(gv));
      check("cmp_uni_vacant",  32'(uni_vacant),     32'(500 - tu));
      check("cmp_gen_full",    32'(gen_full),       32'(gv == 0));
      check("cmp_uni_full",    32'(uni_full),       32'(tu == 500));
      check("cmp_gate_open",   32'(gate_open),      32'(m_pend));
      check("cmp_ent_ready",   32'(ent_ready),      32'(!m_pend));
      check("cmp_ent_grant",   32'(ent_grant),      32'(e_grant));
      check("cmp_ent_deny",    32'(ent_deny),       32'(e_deny));
      check("cmp_ent_timeout", 32'(ent_timeout),    32'(e_timeout));
      check("cmp_ex_err",      32'(ex_err),         32'(e_err));
   endtask

   initial forever begin
      @(negedge clk);
      if (model_valid) compare_all();
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Request, then pulse ent_pass so it is sampled d cycles after the grant
   // edge; returns on the first IDLE cycle afterwards.
   task automatic enter(input bit uni, input int d);
      ent_req = 1'b1; ent_is_uni = uni;
      step();
      ent_req = 1'b0;
      repeat (d - 1) step();
      ent_pass = 1'b1;
      step();
      ent_pass = 1'b0;
   endtask

   // ---------------- directed scenario ----------------
   initial begin
      reset = 1'b1; current_hour = 5'd10;
      ent_req = 1'b0; ent_is_uni = 1'b0; ent_pass = 1'b0;
      ex_req = 1'b0; ex_is_uni = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      step();
      check("rst_parked",    32'(parked_car), 32'd0);
      check("rst_ready",     32'(ent_ready),  32'd1);
      check("rst_gate",      32'(gate_open),  32'd0);
      check("rst_uni_vac",   32'(uni_vacant), 32'd500);
      check("rst_quota_h10", 32'(gen_quota),  32'd200);

      // Uni car at hour 10, pass sampled on the third open cycle.
      ent_req = 1'b1; ent_is_uni = 1'b1;
      step();
      ent_req = 1'b0;
      check("t1_grant",   32'(ent_grant),      32'd1);
      check("t1_uni",     32'(uni_parked_car), 32'd1);
      check("t1_parked",  32'(parked_car),     32'd1);
      check("t1_uni_vac", 32'(uni_vacant),     32'd499);
      check("t1_gate_c1", 32'(gate_open),      32'd1);
      step();
      check("t1_gate_c2", 32'(gate_open),      32'd1);
      step();
      check("t1_gate_c3", 32'(gate_open),      32'd1);
      ent_pass = 1'b1;
      step();
      ent_pass = 1'b0;
      check("t1_gate_closed", 32'(gate_open),  32'd0);
      check("t1_ready",       32'(ent_ready),  32'd1);

      // Hour 9: fill the general quota, then one more is denied.
      current_hour = 5'd9;
      repeat (200) enter(1'b0, 1);
      check("t2_parked",   32'(parked_car), 32'd201);
      check("t2_gen_vac",  32'(gen_vacant), 32'd0);
      check("t2_gen_full", 32'(gen_full),   32'd1);
      ent_req = 1'b1; ent_is_uni = 1'b0;
      step();
      ent_req = 1'b0;
      check("t2_deny",        32'(ent_deny),   32'd1);
      check("t2_no_grant",    32'(ent_grant),  32'd0);
      check("t2_parked_same", 32'(parked_car), 32'd201);
      current_hour = 5'd14;
      #1;
      check("t2_quota_h14",  32'(gen_quota),  32'd300);
      check("t2_gvac_h14",   32'(gen_vacant), 32'd100);
      enter(1'b0, 1);
      check("t2_parked_after", 32'(parked_car), 32'd202);

      // Grant without pass: 16 open cycles, then timeout with rollback.
      ent_req = 1'b1; ent_is_uni = 1'b0;
      step();
      ent_req = 1'b0;
      check("t3_grant",  32'(ent_grant),  32'd1);
      check("t3_parked", 32'(parked_car), 32'd203);
      repeat (16) begin
         check("t3_gate_open", 32'(gate_open), 32'd1);
         step();
      end
      check("t3_gate_closed", 32'(gate_open),   32'd0);
      check("t3_timeout",     32'(ent_timeout), 32'd1);
      check("t3_rollback",    32'(parked_car),  32'd202);

      // Exit underflow: empty lot, then only a pending uni car.
      reset = 1'b1;
      step();
      reset = 1'b0; current_hour = 5'd10;
      ex_req = 1'b1; ex_is_uni = 1'b1;
      step();
      ex_req = 1'b0;
      check("t4_err_empty", 32'(ex_err),         32'd1);
      check("t4_uni_zero",  32'(uni_parked_car), 32'd0);
      check("t4_park_zero", 32'(parked_car),     32'd0);
      step();
      check("t4_err_pulse", 32'(ex_err),         32'd0);
      ent_req = 1'b1; ent_is_uni = 1'b1;
      step();
      ent_req = 1'b0;
      ex_req = 1'b1; ex_is_uni = 1'b1;
      step();
      ex_req = 1'b0;
      check("t4_err_pending", 32'(ex_err),         32'd1);
      check("t4_uni_pending", 32'(uni_parked_car), 32'd1);
      ent_pass = 1'b1;
      step();
      ent_pass = 1'b0;

      // General grant and uni exit on the same edge.
      ent_req = 1'b1; ent_is_uni = 1'b0; ex_req = 1'b1; ex_is_uni = 1'b1;
      step();
      ent_req = 1'b0; ex_req = 1'b0;
      check("t5_grant",  32'(ent_grant),      32'd1);
      check("t5_no_err", 32'(ex_err),         32'd0);
      check("t5_uni",    32'(uni_parked_car), 32'd0);
      check("t5_parked", 32'(parked_car),     32'd1);
      ent_pass = 1'b1;
      step();
      ent_pass = 1'b0;

      // Timeout rollback and general exit together with 4 settled + 1 pending.
      repeat (3) enter(1'b0, 1);
      ent_req = 1'b1; ent_is_uni = 1'b0;
      step();
      ent_req = 1'b0;
      check("t6_parked_pend", 32'(parked_car), 32'd5);
      repeat (15) step();
      ex_req = 1'b1; ex_is_uni = 1'b0;
      step();
      ex_req = 1'b0;
      check("t6_timeout", 32'(ent_timeout), 32'd1);
      check("t6_no_err",  32'(ex_err),      32'd0);
      check("t6_parked",  32'(parked_car),  32'd3);

      // Quota drops below occupancy: vacancy saturates at zero.
      current_hour = 5'd15;
      #1;
      check("t7_quota_h15", 32'(gen_quota),  32'd350);
      check("t7_gvac_h15",  32'(gen_vacant), 32'd347);
      repeat (337) enter(1'b0, 1);
      check("t7_parked",    32'(parked_car), 32'd340);
      check("t7_gvac_340",  32'(gen_vacant), 32'd10);
      current_hour = 5'd9;
      #1;
      check("t7_gvac_sat",  32'(gen_vacant), 32'd0);
      check("t7_gen_full",  32'(gen_full),   32'd1);

      // Reset while OPEN discards the reservation.
      ent_req = 1'b1; ent_is_uni = 1'b1;
      step();
      ent_req = 1'b0;
      check("t8_gate_open", 32'(gate_open),  32'd1);
      check("t8_parked",    32'(parked_car), 32'd341);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t8_gate",   32'(gate_open),      32'd0);
      check("t8_ready",  32'(ent_ready),      32'd1);
      check("t8_parked_zero", 32'(parked_car), 32'd0);
      check("t8_uni",    32'(uni_parked_car), 32'd0);
      check("t8_gvac",   32'(gen_vacant),     32'd200);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parking_gate_manager.md
# parking_gate_manager

Parametrised successor of the lot occupancy controller. It admits university and general cars through a gated entry handshake and reserves the spot on grant. If the car never passes the gate, it releases the spot after a timeout. It also applies an hour-dependent general quota and tracks exits with underflow protection. It sits between the gate/sensor interface and the lot display/status logic.

## Interface
- TOTAL_SPOTS, 700, total lot capacity
- UNI_SPOTS, 500, spots reserved for university cars
- CNT_W, 10, width of all count/vacancy outputs; must satisfy 2**CNT_W > TOTAL_SPOTS
- HOUR_W, 5, width of hour input (0..23)
- GEN_BASE, 200, general quota during hours 8..RAMP_START-1
- GEN_STEP, 50, quota added per hour from RAMP_START up to RAMP_END-1
- RAMP_START, 13 / RAMP_END, 16, quota ramp window
- GATE_TIMEOUT, 16, maximum cycles the entry gate stays open

- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- current_hour  in  HOUR_W  hour of day
- ent_req  in  1  entry request; accepted when ent_req && ent_ready
- ent_is_uni  in  1  class of requesting car; sampled with ent_req
- ent_ready  out  1  high in IDLE only
- ent_pass  in  1  pass-sensor pulse from the gate
- ent_grant / ent_deny / ent_timeout  out  1  one-cycle result pulses
- gate_open  out  1  entry barrier command
- ex_req  in  1  exit event; ex_is_uni  in  1  its class
- ex_err  out  1  one-cycle pulse when an exit would underflow
- parked_car, uni_parked_car  out  CNT_W  registered occupancy, including any pending reservation
- gen_quota, gen_vacant, uni_vacant  out  CNT_W  combinational from registered state and current_hour
- gen_full, uni_full  out  1  gen_vacant==0, uni_vacant==0

## Operation
- gen_parked = parked_car - uni_parked_car.
- gen_quota:
  - hours 8..RAMP_START-1: GEN_BASE.
  - hours RAMP_START..RAMP_END-1: GEN_BASE + GEN_STEP*(hour-RAMP_START+1), giving 250/300/350 with defaults.
  - all other hours: TOTAL_SPOTS - uni_parked_car.
- gen_vacant = gen_quota - gen_parked, saturating at 0 when the quota has dropped below occupancy. uni_vacant = UNI_SPOTS - uni_parked_car.
- Admission rules:
  - Uni car: requires uni_parked_car < UNI_SPOTS and parked_car < TOTAL_SPOTS.
  - General car: requires gen_parked < gen_quota and parked_car < TOTAL_SPOTS.
  - A uni car never falls back to general spots.
- Entry FSM states are IDLE and OPEN.
  - IDLE, accepted request, admitted: increment the class counters, latch the class, pulse ent_grant, raise gate_open, go to OPEN and clear the timer.
  - IDLE, accepted request, not admitted: pulse ent_deny and stay in IDLE.
  - OPEN, ent_pass seen: drop gate_open and go to IDLE; the reservation becomes permanent.
  - OPEN, no ent_pass within GATE_TIMEOUT cycles: drop gate_open, pulse ent_timeout, decrement the latched class counters, go to IDLE.
  - ent_pass is ignored in IDLE. ent_req is not accepted in OPEN.
- Exit handling:
  - An exit may only release a settled car: for ex_is_uni the limit is uni_parked_car minus the pending uni reservation, and for a general exit it is gen_parked minus the pending general reservation.
  - If that count is 0, pulse ex_err and change no counts.
  - Otherwise decrement parked_car, and also uni_parked_car when the exit is uni.
- Simultaneous events: grant, timeout rollback and exit in the same cycle are all applied. The net delta is summed per counter, so no update is lost.
- Reset: FSM goes to IDLE, timer to 0, all counts to 0, all pulses and gate_open to 0, ent_ready to 1. Reset mid-OPEN discards the reservation.

## Timing
- Request accepted at edge N: ent_grant or ent_deny is high in cycle N+1, and counts and vacancies reflect the change in N+1.
- gate_open rises in N+1 and stays high for at most GATE_TIMEOUT cycles.
- ent_pass sampled high at edge M: gate_open is low and ent_ready high from M+1.
- Timeout: ent_timeout pulses in the cycle after the last open cycle, with the rolled-back counts visible in that same cycle.
- Exit at edge N: the count change or ex_err is visible in N+1.
- Back-to-back: a new request can be accepted on the first IDLE cycle after leaving OPEN.

## Structure
- Shared package parking_pkg holds:
  - the entry-state enum (IDLE, OPEN);
  - the default capacity and schedule constants;
  - a gen_quota function of hour and uni count.
- The natural sub-module is parking_entry_gate: the FSM, timeout counter and latched class. It emits grant, deny, timeout and rollback strobes.
- The top level owns the counters and the delta summation.

## Test plan
- Reset, then a uni request at hour 10 with a pass 3 cycles later -> ent_grant in N+1, uni_parked_car=1, parked_car=1, gate_open high for 3 cycles, uni_vacant=499.
- Hour 9 with 200 general cars parked, general request -> ent_deny, counts unchanged. Switch hour to 14 -> gen_quota=300, gen_vacant=100, and the next request is granted.
- Grant with no ent_pass -> gate_open high for exactly 16 cycles, then an ent_timeout pulse with parked_car back to its pre-grant value.
- Uni exit at uni_parked_car=0 -> ex_err pulse, counts stay 0. Uni exit while the only uni car is a pending reservation -> ex_err.
- Timeout rollback and general exit in the same cycle with gen_parked=5 (one pending) -> gen_parked=3.
- Hour 15 with gen_parked=340, then hour 9 -> gen_vacant=0 and gen_full=1 (saturation). Assert reset while in OPEN -> next cycle IDLE, all counts 0, gate_open=0.
